des_ro_mem_port: RTL
====================

# des_ro_mem_port

Memory-side companion of the DES read-only stage: accepts the stage's burst read requests with their task context, issues them on the tile's AXI read channel, and turns each returned beat into one response task carrying data, word index, subtype and a last marker. It owns outstanding-request bookkeeping, ID allocation and narrow-lane extraction, so the RO stage sees one task per returned word. One instance sits between each RO stage and the tile memory arbiter.

## Interface
Parameters:
- TILE_ID, 0, tile index; simulation display only.
- DEPTH, 8, maximum outstanding bursts; must be a power of two.
- ID_W, 3, AXI ID width; must equal log2(DEPTH).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - rstn  in  1  reset, asynchronous, active-low
- Request side, from the RO stage:
  - req_valid  in  1  request present
  - req_ready  out  1  request accepted when req_valid & req_ready
  - req_addr  in  32  byte address of first word
  - req_size  in  3  2 = 32-bit words, 3 = 64-bit words; other values are illegal
  - req_len  in  8  beats minus one
  - req_task  in  task_t  context copied into every response
  - req_subtype  in  subtype_t  subtype for responses
  - req_mark_last  in  1  flag the final response
  - req_cq_slot  in  cq_slice_slot_t  slot copied into responses
- AXI read address channel:
  - m_arvalid  out  1  address valid
  - m_arready  in  1  address accepted
  - m_araddr  out  32  burst address
  - m_arid  out  ID_W  burst ID
  - m_arlen  out  8  burst length
  - m_arsize  out  3  burst size
- AXI read data channel:
  - m_rvalid  in  1  beat valid
  - m_rready  out  1  beat accepted
  - m_rid  in  ID_W  beat ID
  - m_rdata  in  64  beat data
  - m_rlast  in  1  final beat of burst
- Response side, to the RO stage:
  - out_valid  out  1  response present
  - out_ready  in  1  response taken
  - out_task  out  task_t  copied request context
  - out_data  out  ro_data_t  extracted word
  - out_word_id  out  byte_t  beat index of this word
  - out_subtype  out  subtype_t  copied request subtype
  - out_cq_slot  out  cq_slice_slot_t  copied request slot
  - out_last  out  1  final response of a marked burst
- Status:
  - err_sticky  out  1  protocol error seen; cleared only by reset

## Operation
- Context table: DEPTH entries indexed by ID. Each entry holds:
  - valid bit
  - task, subtype, cq_slot, mark_last
  - addr[2], size, len
  - 8-bit beat counter
- Free IDs: the lowest-numbered invalid entry is allocated.
- Request acceptance:
  - req_ready = (any entry free) & (!m_arvalid | m_arready).
  - On accept: the entry becomes valid, its beat counter is set to 0, and the AR register is loaded with addr, ID, len and size.
  - m_arvalid is set and held until m_arready is seen.
- Beat acceptance: m_rready = !out_valid | out_ready. On a beat transfer with a valid entry[m_rid]:
  - size 3: out_data = m_rdata.
  - size 2: lane = addr[2] XOR beat[0]; out_data = {32'b0, lane ? m_rdata[63:32] : m_rdata[31:0]}.
  - out_word_id = beat counter.
  - out_last = mark_last & (beat == len).
  - task, subtype and cq_slot are copied from the entry.
  - The beat counter increments, wrapping at 255.
  - On m_rlast the entry is invalidated. If beat != len at that point, err_sticky is set and the response is still emitted.
- A beat whose m_rid names an invalid entry is accepted and dropped: no response is emitted and err_sticky is set.
- Beats belonging to different IDs may interleave. Per-ID ordering is in order.

## Timing
- Reset values:
  - m_arvalid = 0, out_valid = 0, err_sticky = 0; all entries invalid.
  - req_ready = 1 from the first cycle after reset deasserts.
  - m_rready = 1 after reset.
- Request to m_arvalid: 1 cycle (registered). Back-to-back requests are accepted every cycle while m_arready = 1.
- Beat to out_valid: 1 cycle (registered). One response per cycle at full throughput.
- Output holding: out_* holds stable while out_valid & !out_ready.
- Entry release: the entry is freed in the cycle its m_rlast beat transfers and is allocatable from the next cycle. Same-cycle reuse is not allowed.
- Full table (DEPTH outstanding): req_ready = 0 until a release.
- Simultaneous request accept and release of different entries is legal. Both take effect.
- Reset mid-burst: all contexts are dropped and all valids clear asynchronously. Late beats arriving after reset set err_sticky.

## Test plan
- Single 64-bit request, addr 0x100, len 0, mark_last 1, rdata 0x1122334455667788 -> m_araddr 0x100, m_arid 0; one response with data 0x1122334455667788, word_id 0, out_last 1.
- 32-bit burst, addr 0x204, len 3, beats D0–D3 -> four responses with lanes hi, lo, hi, lo; word_id 0..3; out_last only on word 3.
- Nine requests with DEPTH 8 and memory stalled -> req_ready drops after the 8th accept; it rises one cycle after the first m_rlast transfer, and the 9th request receives the freed ID.
- Interleaved IDs: beats of ID 1 and ID 2 alternate -> each response carries its own task/cq_slot, and per-ID word_id counts are independent.
- out_ready held 0 for 5 cycles mid-burst -> m_rready = 0, out_* stable, no beat lost; the sequence resumes with the correct word_id.
- Beat with an unallocated m_rid = 5 -> no out_valid; err_sticky = 1 and stays 1 until rstn is asserted.

Source files
------------

// File: rtl/des_ro_mem_port.sv
// rtl/des_ro_mem_port.sv - AXI read port for the DES read-only stage
// Tracks outstanding bursts by ID and turns each returned beat into one response task.
package des_ro_pkg;
   typedef logic [15:0] task_t;
   typedef logic [3:0]  subtype_t;
   typedef logic [4:0]  cq_slice_slot_t;
   typedef logic [63:0] ro_data_t;
   typedef logic [7:0]  byte_t;
endpackage

module des_ro_mem_port
   import des_ro_pkg::*;
#(
   parameter int TILE_ID = 0,
   parameter int DEPTH   = 8,
   parameter int ID_W    = 3
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_addr,
   input  logic [2:0]      req_size,
   input  logic [7:0]      req_len,
   input  task_t           req_task,
   input  subtype_t        req_subtype,
   input  logic            req_mark_last,
   input  cq_slice_slot_t  req_cq_slot,
   output logic            m_arvalid,
   input  logic            m_arready,
   output logic [31:0]     m_araddr,
   output logic [ID_W-1:0] m_arid,
   output logic [7:0]      m_arlen,
   output logic [2:0]      m_arsize,
   input  logic            m_rvalid,
   output logic            m_rready,
   input  logic [ID_W-1:0] m_rid,
   input  logic [63:0]     m_rdata,
   input  logic            m_rlast,
   output logic            out_valid,
   input  logic            out_ready,
   output task_t           out_task,
   output ro_data_t        out_data,
   output byte_t           out_word_id,
   output subtype_t        out_subtype,
   output cq_slice_slot_t  out_cq_slot,
   output logic            out_last,
   output logic            err_sticky
);

   if (DEPTH != (1 << ID_W) || TILE_ID < 0) begin : g_bad_cfg
      $error("des_ro_mem_port: DEPTH must equal 2**ID_W");
   end

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] ctx_mark_q;
   logic [DEPTH-1:0] ctx_a2_q;
   task_t            ctx_task_q [DEPTH];
   subtype_t         ctx_sub_q  [DEPTH];
   cq_slice_slot_t   ctx_slot_q [DEPTH];
   logic [2:0]       ctx_size_q [DEPTH];
   logic [7:0]       ctx_len_q  [DEPTH];
   logic [7:0]       ctx_beat_q [DEPTH];

   logic            arvalid_q;
   logic [31:0]     araddr_q;
   logic [ID_W-1:0] arid_q;
   logic [7:0]      arlen_q;
   logic [2:0]      arsize_q;

   logic           out_valid_q;
   task_t          out_task_q;
   ro_data_t       out_data_q;
   ro_data_t       out_data_d;
   byte_t          out_word_id_q;
   subtype_t       out_sub_q;
   cq_slice_slot_t out_slot_q;
   logic           out_last_q;
   logic           err_q;
   logic           err_d;

   logic [ID_W-1:0] free_id;
   logic            any_free;
   logic            req_fire;
   logic            r_fire;
   logic            hit;
   logic [7:0]      cur_beat;
   logic            beat_done;
   logic            lane_hi;

   // Lowest-numbered free entry wins; release only shows up here a cycle later.
   always_comb begin
      free_id  = '0;
      any_free = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_id  = ID_W'(i);
            any_free = 1'b1;
         end
      end
   end

   assign req_ready = any_free & (~arvalid_q | m_arready);
   assign req_fire  = req_valid & req_ready;
   assign m_rready  = ~out_valid_q | out_ready;
   assign r_fire    = m_rvalid & m_rready;
   assign hit       = valid_q[m_rid];
   assign cur_beat  = ctx_beat_q[m_rid];
   assign beat_done = (cur_beat == ctx_len_q[m_rid]);
   assign lane_hi   = ctx_a2_q[m_rid] ^ cur_beat[0];
   assign err_d     = r_fire & (~hit | (m_rlast & ~beat_done));

   // Narrow words alternate halves of the 64-bit beat starting from addr[2].
   always_comb begin
      out_data_d = m_rdata;
      if (ctx_size_q[m_rid] != 3'd3) begin
         out_data_d = {32'b0, lane_hi ? m_rdata[63:32] : m_rdata[31:0]};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q    <= '0;
         ctx_mark_q <= '0;
         ctx_a2_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctx_task_q[i] <= '0;
            ctx_sub_q[i]  <= '0;
            ctx_slot_q[i] <= '0;
            ctx_size_q[i] <= '0;
            ctx_len_q[i]  <= '0;
            ctx_beat_q[i] <= '0;
         end
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         arid_q        <= '0;
         arlen_q       <= '0;
         arsize_q      <= '0;
         out_valid_q   <= 1'b0;
         out_task_q    <= '0;
         out_data_q    <= '0;
         out_word_id_q <= '0;
         out_sub_q     <= '0;
         out_slot_q    <= '0;
         out_last_q    <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         if (req_fire) begin
            valid_q[free_id]    <= 1'b1;
            ctx_mark_q[free_id] <= req_mark_last;
            ctx_a2_q[free_id]   <= req_addr[2];
            ctx_task_q[free_id] <= req_task;
            ctx_sub_q[free_id]  <= req_subtype;
            ctx_slot_q[free_id] <= req_cq_slot;
            ctx_size_q[free_id] <= req_size;
            ctx_len_q[free_id]  <= req_len;
            ctx_beat_q[free_id] <= '0;
            araddr_q            <= req_addr;
            arid_q              <= free_id;
            arlen_q             <= req_len;
            arsize_q            <= req_size;
            arvalid_q           <= 1'b1;
         end else if (m_arready) begin
            arvalid_q <= 1'b0;
         end

         // A hit entry is valid, the allocated one is not, so the two writes never collide.
         if (r_fire && hit) begin
            ctx_beat_q[m_rid] <= cur_beat + 8'd1;
            if (m_rlast) begin
               valid_q[m_rid] <= 1'b0;
            end
            out_valid_q   <= 1'b1;
            out_data_q    <= out_data_d;
            out_word_id_q <= cur_beat;
            out_task_q    <= ctx_task_q[m_rid];
            out_sub_q     <= ctx_sub_q[m_rid];
            out_slot_q    <= ctx_slot_q[m_rid];
            out_last_q    <= ctx_mark_q[m_rid] & beat_done;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (err_d) begin
            err_q <= 1'b1;
         end
      end
   end

   assign m_arvalid   = arvalid_q;
   assign m_araddr    = araddr_q;
   assign m_arid      = arid_q;
   assign m_arlen     = arlen_q;
   assign m_arsize    = arsize_q;
   assign out_valid   = out_valid_q;
   assign out_task    = out_task_q;
   assign out_data    = out_data_q;
   assign out_word_id = out_word_id_q;
   assign out_subtype = out_sub_q;
   assign out_cq_slot = out_slot_q;
   assign out_last    = out_last_q;
   assign err_sticky  = err_q;

endmodule
